fir_tap_loader: RTL and testbench
=================================

Name: fir_tap_loader

Overview:
Producer end of the MAC datapath. Accepts a serial stream of raw sensor samples and shifts them into a NUM_REGS-deep tap delay line. Holds a writable coefficient bank and presents both as parallel vectors (pDataOut, coefsOut) with a valid/ready handshake, so the MAC sees stable operands for each output computation.

Parameters:
DATA_WIDTH, 16, width of each sample and coefficient (shared constant)
NUM_REGS, 8, number of taps (shared constant)
CNT_WIDTH, $clog2(NUM_REGS+1), width of fillCount

Ports:
clk  input  1  system clock, all logic on rising edge
rstN  input  1  synchronous active-low reset
sampleIn  input  DATA_WIDTH  incoming raw sample
sampleValid  input  1  sampleIn is valid
sampleReady  output  1  block can accept a sample this cycle
coefWrEn  input  1  coefficient write request
coefAddr  input  $clog2(NUM_REGS)  coefficient index
coefData  input  DATA_WIDTH  coefficient value
coefWrReady  output  1  coefficient write accepted this cycle
flush  input  1  clear the delay line
pDataOut  output  [DATA_WIDTH-1:0] x NUM_REGS  parallel taps; index 0 is newest
coefsOut  output  [DATA_WIDTH-1:0] x NUM_REGS  parallel coefficients
tapsValid  output  1  pDataOut/coefsOut form a new operand set
tapsReady  input  1  MAC consumes the operand set
fillCount  output  CNT_WIDTH  samples in the line, saturating at NUM_REGS
primed  output  1  fillCount == NUM_REGS

Behaviour:
- Clock and reset: one clock, clk. Reset rstN is synchronous and active-low.
- Reset (rstN low at a rising edge): all taps = 0, all coefs = 0, tapsValid = 0, fillCount = 0, primed = 0, state = IDLE. sampleReady and coefWrReady are forced 0 while rstN is low.
- States: IDLE (tapsValid = 0) and PRESENT (tapsValid = 1). tapsValid is a registered output equal to (state == PRESENT).
- sampleReady = !tapsValid || tapsReady, combinational. This gives back-to-back throughput of one sample per cycle.
- Sample accept happens when sampleValid && sampleReady at an edge. On the next cycle:
  - pDataOut[0] = sampleIn and pDataOut[i] = old pDataOut[i-1]; the oldest tap is dropped.
  - state = PRESENT.
  - fillCount increments, saturating at NUM_REGS.
  - Latency from accept to tapsValid is 1 cycle.
- Consume happens when tapsValid && tapsReady at an edge. If no sample is accepted in the same edge, state = IDLE. Simultaneous consume and accept keeps state PRESENT with the new shifted taps.
- Hold: while tapsValid && !tapsReady, pDataOut, coefsOut and tapsValid are stable and sampleReady = 0.
- Output while filling: the line starts zero-filled, so tapsValid asserts after every accepted sample, including before primed. Whether to ignore results before primed is the consumer's choice.
- Coefficient writes:
  - coefWrReady = !tapsValid || tapsReady, so coefs never change under a held operand set.
  - A write executes when coefWrEn && coefWrReady. coefsOut[coefAddr] updates on the next cycle.
  - coefAddr >= NUM_REGS is ignored with no state change, but coefWrReady still follows the rule above.
  - A write and a sample accept in the same edge are both performed. The new operand set carries the new coefficient.
- flush (sampled at the edge, rstN high):
  - Clears all taps to 0, fillCount = 0, state = IDLE (tapsValid drops next cycle).
  - Has priority over a simultaneous sample accept; that sample is discarded even if sampleReady was 1.
  - A simultaneous coefficient write still executes. Coefs are never cleared by flush.
- Reset mid-operation: reset overrides flush, accept and write. All state returns to reset values on that edge.
- Arithmetic: no arithmetic on data; samples and coefs are passed through bit-exact. fillCount never exceeds NUM_REGS and never wraps.

Decomposition:
- Shared constants header (constants.vh): DATA_WIDTH, NUM_REGS and a derived TAP_ADDR_WIDTH = $clog2(NUM_REGS). A state enum (IDLE, PRESENT) belongs in the shared package for reuse by the MAC control.
- One natural sub-module: coef_bank. It is a NUM_REGS x DATA_WIDTH register file with write enable/address, synchronous reset and parallel read-out.
- The delay line, FSM and fillCount stay in fir_tap_loader.

Test Plan:
1. Reset, then push samples 1..8 with tapsReady = 1 → one tapsValid pulse per sample, each 1 cycle after accept. After the 8th: pDataOut = {8,7,6,5,4,3,2,1}, fillCount = 8, primed = 1.
2. Backpressure: tapsReady = 0 after sample 5 and sampleValid held with value 9 → sampleReady = 0, outputs frozen for 10 cycles. Raising tapsReady accepts 9 in the same edge; next cycle pDataOut[0] = 9 and tapsValid stays 1.
3. Coef load: write addr 0..7 = 10..17 while idle → coefsOut = {10..17}. Write addr 3 = 99 while tapsValid = 1 and tapsReady = 0 → coefWrReady = 0, coefsOut[3] stays 13 until tapsReady = 1.
4. Out-of-range write (NUM_REGS = 8, addr 8 via a widened bench or a NUM_REGS = 6 build with addr 6) → no coefficient changes.
5. flush asserted in the same cycle as a sample accept (value 0x55) → all taps 0, fillCount = 0, tapsValid = 0, 0x55 absent. Coefs retained; a simultaneous coef write executes.
6. rstN low for 1 cycle while PRESENT with held data → next cycle all taps/coefs = 0, tapsValid = 0. sampleReady = 0 during reset and 1 the cycle after.

Source files
------------

// File: rtl/fir_tap_loader_pkg.sv
// Shared constants and state type for the tap loader and the MAC control.
// Holds the default sample/coefficient width, the tap count and the derived tap address width.
// The operand-presentation state enum lives here so the MAC side can reuse it.
package fir_tap_loader_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_NUM_REGS       = 8;
    localparam int DEF_TAP_ADDR_WIDTH = $clog2(DEF_NUM_REGS);

    // IDLE: no operand set on offer. PRESENT: pDataOut/coefsOut are an unconsumed set.
    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } tap_state_e;

endpackage

// File: rtl/fir_tap_loader_coef_bank.sv
// Coefficient register file: NUM_REGS x DATA_WIDTH, one write port, full parallel read-out.
// Ports: clk, rst_n (sync, active-low), wr_en/wr_addr/wr_data write port, rd_data flat vector.
// Write lands one cycle later; addresses >= NUM_REGS are dropped without touching any entry.
module fir_tap_loader_coef_bank
    import fir_tap_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] coefs [NUM_REGS];
    logic                  in_range;

    // Widen by one bit so the comparison also works when NUM_REGS is a power of two.
    assign in_range = ({1'b0, wr_addr} < (ADDR_WIDTH + 1)'(NUM_REGS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                coefs[i] <= '0;
            end
        end else if (wr_en && in_range) begin
            coefs[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_rd
        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = coefs[g];
    end

endmodule

// File: rtl/fir_tap_loader.sv
// Sample delay line + coefficient bank presenting parallel MAC operands with valid/ready.
// Ports: sample in (valid/ready), coef write port (en/ready), flush, taps/coefs out (valid/ready), fill status.
// Accept-to-tapsValid latency 1 cycle; a held operand set (tapsValid && !tapsReady) stalls samples and coef writes.
module fir_tap_loader
    import fir_tap_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int CNT_WIDTH  = $clog2(NUM_REGS + 1),
    localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             rstN,
    input  logic [DATA_WIDTH-1:0]            sampleIn,
    input  logic                             sampleValid,
    output logic                             sampleReady,
    input  logic                             coefWrEn,
    input  logic [ADDR_WIDTH-1:0]            coefAddr,
    input  logic [DATA_WIDTH-1:0]            coefData,
    output logic                             coefWrReady,
    input  logic                             flush,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   pDataOut,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   coefsOut,
    output logic                             tapsValid,
    input  logic                             tapsReady,
    output logic [CNT_WIDTH-1:0]             fillCount,
    output logic                             primed
);

    localparam logic [CNT_WIDTH-1:0] FILL_FULL = CNT_WIDTH'(NUM_REGS);

    tap_state_e            state;
    tap_state_e            state_nxt;
    logic [DATA_WIDTH-1:0] taps [NUM_REGS];
    logic [CNT_WIDTH-1:0]  fill_cnt;
    logic                  can_take;
    logic                  accept;
    logic                  consume;

    // Samples and coef writes share one rule: only move when no set is being held.
    // Both are gated off while reset is asserted.
    assign can_take    = rstN && (!tapsValid || tapsReady);
    assign sampleReady = can_take;
    assign coefWrReady = can_take;

    assign accept  = sampleValid && can_take;
    assign consume = tapsValid && tapsReady;

    // State register; tapsValid is taken straight from it so it is glitch-free.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush wins over a same-edge accept; accept wins over consume so that
    // back-to-back traffic keeps tapsValid high.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = PRESENT;
        end else if (consume) begin
            state_nxt = IDLE;
        end
    end

    assign tapsValid = (state == PRESENT);

    // Delay line and fill counter. A flushed edge discards the incoming sample.
    always_ff @(posedge clk) begin
        if (!rstN || flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                taps[i] <= '0;
            end
            fill_cnt <= '0;
        end else if (accept) begin
            for (int i = NUM_REGS - 1; i > 0; i--) begin
                taps[i] <= taps[i-1];
            end
            taps[0] <= sampleIn;
            if (fill_cnt != FILL_FULL) begin
                fill_cnt <= fill_cnt + CNT_WIDTH'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_taps
        assign pDataOut[g*DATA_WIDTH +: DATA_WIDTH] = taps[g];
    end

    assign fillCount = fill_cnt;
    assign primed    = (fill_cnt == FILL_FULL);

    // Coefs are untouched by flush; a write on a flushed edge still lands.
    fir_tap_loader_coef_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_coef_bank (
        .clk     (clk),
        .rst_n   (rstN),
        .wr_en   (coefWrEn && can_take),
        .wr_addr (coefAddr),
        .wr_data (coefData),
        .rd_data (coefsOut)
    );

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader built with NUM_REGS = 6 so that addresses 6 and 7 are out of range.
// Directed phases pin literal values; a random phase runs against a queue-based reference model.
// A compare process checks every output on every falling edge once reset has been applied.
module tb_fir_tap_loader;

    localparam int DW = 16;
    localparam int NR = 6;
    localparam int AW = $clog2(NR);
    localparam int CW = $clog2(NR + 1);

    logic                clk = 1'b0;
    logic                rstN;
    logic [DW-1:0]       sampleIn;
    logic                sampleValid;
    logic                sampleReady;
    logic                coefWrEn;
    logic [AW-1:0]       coefAddr;
    logic [DW-1:0]       coefData;
    logic                coefWrReady;
    logic                flush;
    logic [NR*DW-1:0]    pDataOut;
    logic [NR*DW-1:0]    coefsOut;
    logic                tapsValid;
    logic                tapsReady;
    logic [CW-1:0]       fillCount;
    logic                primed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_tap_loader #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .sampleIn    (sampleIn),
        .sampleValid (sampleValid),
        .sampleReady (sampleReady),
        .coefWrEn    (coefWrEn),
        .coefAddr    (coefAddr),
        .coefData    (coefData),
        .coefWrReady (coefWrReady),
        .flush       (flush),
        .pDataOut    (pDataOut),
        .coefsOut    (coefsOut),
        .tapsValid   (tapsValid),
        .tapsReady   (tapsReady),
        .fillCount   (fillCount),
        .primed      (primed)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] tap(input int i);
        return pDataOut[i*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] coef(input int i);
        return coefsOut[i*DW +: DW];
    endfunction

    // ---------------- reference model ----------------
    // Delay line as a queue: newest at the front, fixed length NR.
    int m_line[$];
    int m_coef[NR];
    bit m_valid;
    int m_fill;
    bit m_live = 1'b0;

    always @(posedge clk) begin : model
        bit rdy, acc, cons;
        if (!rstN) begin
            m_line.delete();
            for (int i = 0; i < NR; i++) begin
                m_line.push_back(0);
                m_coef[i] = 0;
            end
            m_valid = 1'b0;
            m_fill  = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            rdy  = !m_valid || tapsReady;
            acc  = sampleValid && rdy;
            cons = m_valid && tapsReady;
            if (coefWrEn && rdy && int'(coefAddr) < NR) m_coef[coefAddr] = int'(coefData);
            if (flush) begin
                for (int i = 0; i < NR; i++) m_line[i] = 0;
                m_fill  = 0;
                m_valid = 1'b0;
            end else if (acc) begin
                m_line.push_front(int'(sampleIn));
                void'(m_line.pop_back());
                m_fill  = (m_fill < NR) ? m_fill + 1 : NR;
                m_valid = 1'b1;
            end else if (cons) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit exp_rdy;
        if (m_live) begin
            exp_rdy = rstN && (!m_valid || tapsReady);
            chk("tapsValid",   64'(tapsValid),   64'(m_valid));
            chk("sampleReady", 64'(sampleReady), 64'(exp_rdy));
            chk("coefWrReady", 64'(coefWrReady), 64'(exp_rdy));
            chk("fillCount",   64'(fillCount),   64'(m_fill));
            chk("primed",      64'(primed),      64'(m_fill == NR));
            for (int i = 0; i < NR; i++) begin
                chk($sformatf("tap[%0d]", i),  64'(tap(i)),  64'(m_line[i]));
                chk($sformatf("coef[%0d]", i), 64'(coef(i)), 64'(m_coef[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        sampleValid = 1'b1;
        sampleIn    = DW'(v);
        settle();
        sampleValid = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; sampleIn = '0; sampleValid = 1'b0; coefWrEn = 1'b0;
        coefAddr = '0; coefData = '0; flush = 1'b0; tapsReady = 1'b0;

        // Reset state
        settle();
        @(negedge clk);
        chk("rst_tapsValid", 64'(tapsValid), 64'd0);
        chk("rst_fillCount", 64'(fillCount), 64'd0);
        chk("rst_sampleReady", 64'(sampleReady), 64'd0);
        settle();
        rstN = 1'b1;

        // Fill: 1..8 back to back; line saturates at 6
        tapsReady = 1'b1;
        for (int v = 1; v <= 8; v++) push(v);
        @(negedge clk);
        chk("fill_valid", 64'(tapsValid), 64'd1);
        for (int i = 0; i < NR; i++) chk($sformatf("fill_tap%0d", i), 64'(tap(i)), 64'(8 - i));
        chk("fill_count", 64'(fillCount), 64'd6);
        chk("fill_primed", 64'(primed), 64'd1);
        settle();
        @(negedge clk);
        chk("consumed_valid", 64'(tapsValid), 64'd0);

        // Backpressure
        settle();
        flush = 1'b1;
        settle();
        flush = 1'b0;
        for (int v = 1; v <= 4; v++) push(v);
        sampleValid = 1'b1; sampleIn = 16'd5;
        settle();
        tapsReady = 1'b0; sampleIn = 16'd9;
        repeat (10) begin
            @(negedge clk);
            chk("bp_sampleReady", 64'(sampleReady), 64'd0);
            chk("bp_tap0", 64'(tap(0)), 64'd5);
            chk("bp_valid", 64'(tapsValid), 64'd1);
            settle();
        end
        tapsReady = 1'b1;
        settle();
        sampleValid = 1'b0;
        @(negedge clk);
        chk("bp_tap0_after", 64'(tap(0)), 64'd9);
        chk("bp_tap1_after", 64'(tap(1)), 64'd5);
        chk("bp_valid_after", 64'(tapsValid), 64'd1);
        chk("bp_fill_after", 64'(fillCount), 64'd6);

        // Coefficient load while idle, then a write under a held set
        settle();
        for (int a = 0; a < NR; a++) begin
            coefWrEn = 1'b1; coefAddr = AW'(a); coefData = DW'(10 + a);
            settle();
        end
        coefWrEn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) chk($sformatf("coef_load%0d", i), 64'(coef(i)), 64'(10 + i));
        settle();
        tapsReady = 1'b0;
        push(20);
        coefWrEn = 1'b1; coefAddr = 3'd3; coefData = 16'd99;
        repeat (3) begin
            @(negedge clk);
            chk("hold_coefWrReady", 64'(coefWrReady), 64'd0);
            chk("hold_coef3", 64'(coef(3)), 64'd13);
            settle();
        end
        tapsReady = 1'b1;
        settle();
        coefWrEn = 1'b0;
        @(negedge clk);
        chk("release_coef3", 64'(coef(3)), 64'd99);

        // Out-of-range addresses
        settle();
        coefWrEn = 1'b1; coefAddr = 3'd6; coefData = 16'hBEEF;
        settle();
        coefAddr = 3'd7;
        settle();
        coefWrEn = 1'b0;
        @(negedge clk);
        begin
            int exp_c[NR] = '{10, 11, 12, 99, 14, 15};
            for (int i = 0; i < NR; i++) chk($sformatf("oor_coef%0d", i), 64'(coef(i)), 64'(exp_c[i]));
        end

        // Flush colliding with a sample accept and a coef write
        settle();
        push(16'h11);
        push(16'h22);
        flush = 1'b1; sampleValid = 1'b1; sampleIn = 16'h55;
        coefWrEn = 1'b1; coefAddr = 3'd1; coefData = 16'h77;
        settle();
        flush = 1'b0; sampleValid = 1'b0; coefWrEn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) chk($sformatf("flush_tap%0d", i), 64'(tap(i)), 64'd0);
        chk("flush_fill", 64'(fillCount), 64'd0);
        chk("flush_valid", 64'(tapsValid), 64'd0);
        chk("flush_coef1", 64'(coef(1)), 64'h77);
        chk("flush_coef0", 64'(coef(0)), 64'd10);

        // Reset while holding a set
        settle();
        tapsReady = 1'b0;
        push(16'h33);
        @(negedge clk);
        chk("prerst_valid", 64'(tapsValid), 64'd1);
        settle();
        rstN = 1'b0; tapsReady = 1'b1;
        @(negedge clk);
        chk("inrst_sampleReady", 64'(sampleReady), 64'd0);
        chk("inrst_coefWrReady", 64'(coefWrReady), 64'd0);
        settle();
        rstN = 1'b1;
        @(negedge clk);
        chk("postrst_valid", 64'(tapsValid), 64'd0);
        chk("postrst_tap0", 64'(tap(0)), 64'd0);
        chk("postrst_coef3", 64'(coef(3)), 64'd0);
        chk("postrst_sampleReady", 64'(sampleReady), 64'd1);

        // Random traffic against the model
        settle();
        repeat (3000) begin
            rstN        = ($urandom_range(0, 199) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            sampleValid = ($urandom_range(0, 3) != 0);
            sampleIn    = DW'($urandom);
            tapsReady   = ($urandom_range(0, 2) != 0);
            coefWrEn    = ($urandom_range(0, 4) == 0);
            coefAddr    = AW'($urandom_range(0, 7));
            coefData    = DW'($urandom);
            settle();
        end
        rstN = 1'b1; flush = 1'b0; sampleValid = 1'b0; coefWrEn = 1'b0;
        repeat (3) settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
